// File: rtl/approx_mac_acc_pkg.sv
// Shared types and constants for the approximate-multiplier MAC accumulator.
package approx_mac_pkg;

    typedef enum logic {ST_ACC, ST_DONE} state_e;

    localparam int PROD_W_DEF  = 16;
    localparam int ACC_W_DEF   = 24;
    localparam int MAX_LEN_DEF = 256;

    // Counter must represent MAX_LEN itself, hence the +1.
    function automatic int cnt_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/approx_mac_acc_if.sv
// Product-in / result-out handshake bundle for approx_mac_acc.
interface approx_mac_acc_if
    import approx_mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = cnt_w(MAX_LEN_DEF)
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/approx_mac_acc_sat_add.sv
// Accumulator adder: ACC_W + zero-extended PROD_W, with carry-out as overflow
// and an optional clamp to all-ones.
module approx_sat_add #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int SAT    = 1
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);
    logic [ACC_W:0] full;

    // One extra bit captures the carry out of the accumulator width.
    always_comb begin
        full = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
        ovf  = full[ACC_W];
        // A clamped accumulator re-overflows on any nonzero term, so it sticks.
        sum  = ((SAT != 0) && ovf) ? {ACC_W{1'b1}} : full[ACC_W-1:0];
    end
endmodule

// File: rtl/approx_mac_acc.sv
// Packet accumulator for approximate-multiplier products: sums beats until
// in_last or MAX_LEN, then holds one result beat until the consumer takes it.
module approx_mac_acc
    import approx_mac_pkg::*;
#(
    parameter int  PROD_W  = PROD_W_DEF,
    parameter int  ACC_W   = ACC_W_DEF,
    parameter int  MAX_LEN = MAX_LEN_DEF,
    parameter int  SAT     = 1,
    localparam int CNT_W   = cnt_w(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    approx_mac_acc_if.slave  bus
);
    state_e           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             rdy;
    logic             accept;
    logic             close;
    logic             take;

    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_ovf_q;

    approx_sat_add #(.PROD_W(PROD_W), .ACC_W(ACC_W), .SAT(SAT)) u_add (
        .a   (acc),
        .b   (bus.in_prod),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_ACC;
        else        state <= state_nxt;
    end

    // Handshake decode and next-state logic; clr always returns to ACC.
    always_comb begin
        state_nxt = state;
        cnt_inc   = cnt + 1'b1;
        rdy       = (state == ST_ACC) && !clr && rst_n;
        accept    = bus.in_valid && rdy;
        close     = accept && (bus.in_last || (cnt_inc == CNT_W'(MAX_LEN)));
        take      = (state == ST_DONE) && bus.out_ready && !clr;
        if (clr) begin
            state_nxt = ST_ACC;
        end else begin
            case (state)
                ST_ACC:  if (close) state_nxt = ST_DONE;
                ST_DONE: if (bus.out_ready) state_nxt = ST_ACC;
                default: state_nxt = ST_ACC;
            endcase
        end
    end

    // Running sum, term count, sticky overflow and the held result beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (clr) begin
            // Result registers keep their last values; only validity drops.
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            acc <= add_sum;
            cnt <= cnt_inc;
            ovf <= ovf | add_ovf;
            if (close) begin
                out_sum_q   <= add_sum;
                out_count_q <= cnt_inc;
                out_ovf_q   <= ovf | add_ovf;
                out_valid_q <= 1'b1;
            end
        end else if (take) begin
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
